// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, data width and baud divisor helper.
// Intended for reuse by the transmitter and a future receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Rounded clk_hz/baud, e.g. 100 MHz / 9600 baud -> 10417.
    function automatic int calc_clks_per_bit(input longint clk_hz, input longint baud);
        return int'((clk_hz + (baud / 2)) / baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the final count.
// clear holds the counter at zero so a new frame always starts on a full bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == LAST);
    assign tick   = w_last;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with 1 or 2 stop bits; one byte per tx_dv/tx_ready handshake,
// shifted LSB-first on a registered tx_serial line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tx_dv,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          r_state,   w_state_next;
    logic [DATA_BITS-1:0] r_shift,   w_shift_next;
    logic [2:0]           r_bit_idx, w_bit_idx_next;
    logic                 r_serial,  w_serial_next;
    logic [2:0]           w_idx_inc;
    logic                 w_tick;
    logic                 w_clear;
    logic                 w_done;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .tick    (w_tick)
    );

    assign w_idx_inc = r_bit_idx + 3'd1;

    // NOTE: the shift register is reset too, so no X ever reaches the line after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_serial  <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_serial  <= w_serial_next;
        end
    end

    // tx_serial is computed one step ahead so it changes on the edge entering each bit.
    always_comb begin
        // NOTE: every output gets a default first; a missed branch then holds, never latches.
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_serial_next  = r_serial;
        w_clear        = 1'b0;
        w_done         = 1'b0;

        case (r_state)
            IDLE: begin
                w_clear       = 1'b1;
                w_serial_next = 1'b1;
                if (tx_dv) begin
                    w_state_next   = START;
                    w_shift_next   = tx_byte;
                    w_bit_idx_next = '0;
                    w_serial_next  = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                    w_serial_next  = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next   = STOP;
                        w_bit_idx_next = '0;
                        w_serial_next  = 1'b1;
                    end else begin
                        w_bit_idx_next = w_idx_inc;
                        w_serial_next  = r_shift[w_idx_inc];
                    end
                end
            end
            STOP: begin
                // The bit index is reused to count stop bits.
                if (w_tick) begin
                    if (r_bit_idx == LAST_STOP) begin
                        w_state_next   = IDLE;
                        w_bit_idx_next = '0;
                        w_done         = 1'b1;
                    end else begin
                        w_bit_idx_next = w_idx_inc;
                    end
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_serial_next = 1'b1;
            end
        endcase
    end

    assign tx_ready  = (r_state == IDLE);
    assign tx_serial = r_serial;
    assign tx_done   = w_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: two transmitter configurations (4 clk/bit 1 stop, 5 clk/bit 2 stop)
// compared cycle by cycle against an arithmetic model of the UART frame.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       dv_a = 1'b0, dv_b = 1'b0;
    logic [7:0] byte_a = '0, byte_b = '0;
    logic       ready_a, serial_a, done_a;
    logic       ready_b, serial_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_dv     (dv_a),
        .tx_byte   (byte_a),
        .tx_ready  (ready_a),
        .tx_serial (serial_a),
        .tx_done   (done_a)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(5), .STOP_BITS(2)) u_dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_dv     (dv_b),
        .tx_byte   (byte_b),
        .tx_ready  (ready_b),
        .tx_serial (serial_b),
        .tx_done   (done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic dv, input logic [7:0] b);
        if (sel == 0) begin
            dv_a   = dv;
            byte_a = b;
        end else begin
            dv_b   = dv;
            byte_b = b;
        end
    endtask

    task automatic read_outs(input int sel, output logic s, output logic r, output logic d);
        if (sel == 0) begin
            s = serial_a; r = ready_a; d = done_a;
        end else begin
            s = serial_b; r = ready_b; d = done_b;
        end
    endtask

    // Expected line level k cycles after the start-bit edge: bit slot k/cpb of {0, data LSB first, 1...}.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int cpb);
        int slot = k / cpb;
        if (slot == 0)  return 1'b0;
        if (slot <= 8)  return b[slot-1];
        return 1'b1;
    endfunction

    task automatic idle_cycles(input int sel, input int n);
        logic s, r, d;
        for (int i = 0; i < n; i++) begin
            read_outs(sel, s, r, d);
            check("idle serial", s, 1);
            check("idle ready", r, 1);
            check("idle done", d, 0);
            @(negedge clk);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge where tx_ready must be high again.
    task automatic run_frame(input int sel, input logic [7:0] b, input bit busy_poke);
        int         cpb   = (sel == 0) ? 4 : 5;
        int         nstop = (sel == 0) ? 1 : 2;
        int         n     = (9 + nstop) * cpb;
        logic       s, r, d;
        logic [7:0] dec = '0;
        int         n_done = 0;

        read_outs(sel, s, r, d);
        check("pre-accept ready", r, 1);
        check("pre-accept serial", s, 1);
        drive(sel, 1'b1, b);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 8'($urandom));

        for (int k = 0; k < n; k++) begin
            if (busy_poke && k == 5 * cpb)     drive(sel, 1'b1, 8'h55);
            if (busy_poke && k == 5 * cpb + 3) drive(sel, 1'b0, 8'($urandom));
            read_outs(sel, s, r, d);
            check("frame serial", s, frame_bit(b, k, cpb));
            check("frame ready", r, 0);
            check("frame done", d, (k == n - 1));
            if (d) n_done++;
            if ((k / cpb) >= 1 && (k / cpb) <= 8 && (k % cpb) == cpb / 2)
                dec[(k / cpb) - 1] = s;
            @(negedge clk);
        end
        check("decoded byte", dec, b);
        check("done pulse count", n_done, 1);
        read_outs(sel, s, r, d);
        check("post-frame ready", r, 1);
        check("post-frame serial", s, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       s, r, d;
        logic [7:0] msg [6];
        msg = '{8'h2D, 8'h31, 8'h32, 8'h35, 8'h0D, 8'h0A};

        // Reset held for 3 cycles, then released with tx_dv low.
        #1 reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int sel = 0; sel < 2; sel++) begin
                read_outs(sel, s, r, d);
                check("reset serial", s, 1);
                check("reset ready", r, 1);
                check("reset done", d, 0);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        idle_cycles(0, 3);
        idle_cycles(1, 1);

        // Single '+' frame.
        run_frame(0, 8'h2B, 1'b0);
        idle_cycles(0, 2);

        // tx_dv with 0x55 mid-frame of 0xA3 is ignored and not queued.
        run_frame(0, 8'hA3, 1'b1);
        idle_cycles(0, 4);

        // Reset during data bit 4 of 0x00.
        drive(0, 1'b1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (21) @(negedge clk);
        check("bit4 before reset", serial_a, 0);
        check("ready before reset", ready_a, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async reset serial", serial_a, 1);
        check("async reset ready", ready_a, 1);
        check("async reset done", done_a, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("in-reset serial", serial_a, 1);
            check("in-reset done", done_a, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        idle_cycles(0, 2);
        run_frame(0, 8'h0D, 1'b0);

        // Formatter-style message sent back to back.
        foreach (msg[i]) run_frame(0, msg[i], 1'b0);
        idle_cycles(0, 1);

        // Two stop bits, 5 clk/bit, back-to-back pair.
        run_frame(1, 8'hFF, 1'b0);
        run_frame(1, 8'($urandom), 1'b0);
        idle_cycles(1, 2);

        // Randomized frames on either configuration.
        for (int i = 0; i < 10; i++) begin
            int sel = int'($urandom_range(0, 1));
            idle_cycles(sel, int'($urandom_range(0, 2)));
            run_frame(sel, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Serial UART transmitter (8N1, configurable stop bits) that sits directly downstream of the vending-machine ASCII message formatter. It accepts one byte per handshake on tx_dv/tx_byte, reports availability on tx_ready, and shifts the frame out LSB-first on tx_serial. tx_ready stays low for the whole frame, so the upstream formatter advances its character pointer on the falling edge of tx_ready.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per bit period (100 MHz / 9600 baud); legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
tx_dv  input  1  byte valid from upstream; sampled only while tx_ready=1
tx_byte  input  8  byte to send; captured on the accept cycle
tx_ready  output  1  high only in IDLE; low from the cycle after accept until the frame completes
tx_serial  output  1  UART line; idles high
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, tx_serial=1, tx_ready=1, tx_done=0, baud counter=0, bit index=0, shift register=0. Reset asserted mid-frame aborts the frame immediately: line returns high with no glitch low, and no tx_done pulse.
- Accept: tx_dv=1 && tx_ready=1 at a rising edge -> latch tx_byte into the shift register and go to START. tx_ready=0 from the next cycle onward.
- tx_dv while tx_ready=0 is ignored, with no queuing. tx_byte is not required to stay stable after the accept edge.
- Per-bit timing uses a baud counter from 0 to CLKS_PER_BIT-1. A bit ends when the counter reaches CLKS_PER_BIT-1. The counter then wraps to 0.
- Each state holds tx_serial for exactly CLKS_PER_BIT cycles per bit.
- States and transitions:
  - IDLE: tx_serial=1, tx_ready=1. On accept -> START.
  - START: tx_serial=0 for one bit period -> DATA, bit index=0.
  - DATA: tx_serial=shift[bit index], LSB first. At the end of each bit, if bit index=7 -> STOP; otherwise increment the index.
  - STOP: tx_serial=1 for STOP_BITS bit periods. tx_done=1 on the final cycle. Then -> IDLE.
- Registered outputs: tx_serial changes on the clock edge that enters a state, with no combinational path from tx_dv to tx_serial.
- Latency: accept edge to the start-bit falling edge on tx_serial is 1 clock.
- Frame length from start-bit edge to tx_ready rising is (9+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames: tx_ready=1 for at least 1 cycle between frames. A new accept in that cycle starts the next start bit on the following edge, giving an inter-frame gap of 1 clock of idle-high.
- Counter width is $clog2(CLKS_PER_BIT). The bit index is 3 bits and never wraps past 7.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - DATA_BITS=8
  - function computing CLKS_PER_BIT from CLK_HZ and BAUD, for reuse by a future uart_rx.
- Sub-module uart_baud_tick: parameter CLKS_PER_BIT; inputs clk, reset_n, clear; output tick, a one-cycle pulse at count CLKS_PER_BIT-1. The FSM asserts clear on accept.
- The FSM, shift register and bit index stay in the top module.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with CLKS_PER_BIT=4 -> tx_serial=1, tx_ready=1, tx_done=0. Release -> outputs unchanged while tx_dv=0.
- Single byte 0x2B ('+'), CLKS_PER_BIT=4, STOP_BITS=1:
  - tx_ready falls 1 cycle after accept.
  - tx_serial shows 0 | 1,1,0,1,0,1,0,0 | 1, each bit held 4 cycles.
  - tx_done pulses once, at cycle 40 after the start edge.
  - tx_ready rises the next cycle.
- Upstream integration: connect the ASCII formatter and change amount_bcd to 0x125 with give_change=1 -> serial decoder captures "-125\r\n" (0x2D,0x31,0x32,0x35,0x0D,0x0A) with no dropped or duplicated bytes.
- Busy ignore: assert tx_dv with 0x55 mid-frame of 0xA3 -> only 0xA3 is transmitted, and tx_ready stays 0 until the frame ends.
- Reset mid-frame: pull reset_n low during DATA bit 4 of 0x00 -> tx_serial=1 asynchronously (before the next clk edge) and no tx_done pulse. After release, a new accept of 0x0D sends a clean frame.
- STOP_BITS=2, CLKS_PER_BIT=5, byte 0xFF -> stop-high time is 10 cycles and the total frame is 55 cycles. A back-to-back second byte has an idle gap of 1 cycle.
